// File: rtl/uart_param_fifo.sv
// uart_param_fifo: parameterised first-word-fall-through FIFO with a
// programmable watermark and sticky overflow/underflow error flags.
//
// Ports:
//   clk, reset          rising-edge clock, asynchronous active-high reset
//   wr_en, wr_data      push request and push word
//   rd_en, rd_data      pop request and head word (valid while empty=0)
//   flush               discard all contents, highest priority
//   thresh              watermark, 0..DEPTH (0 disables thresh_hit)
//   clr_err             clears the sticky error flags
//   level, full, empty  occupancy status, decoded from the count register
//   thresh_hit          level >= thresh (thresh != 0)
//   overflow, underflow sticky error flags
module uart_param_fifo #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       wr_en,
  input  logic [DATA_W-1:0]          wr_data,
  input  logic                       rd_en,
  output logic [DATA_W-1:0]          rd_data,
  input  logic                       flush,
  input  logic [$clog2(DEPTH):0]     thresh,
  input  logic                       clr_err,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       full,
  output logic                       empty,
  output logic                       thresh_hit,
  output logic                       overflow,
  output logic                       underflow
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [CW-1:0]     count;

  logic pop_ok;
  logic push_ok;
  logic ovf_event;
  logic unf_event;

  // Status decode straight from the count register.
  assign level      = count;
  assign full       = (count == CW'(DEPTH));
  assign empty      = (count == '0);
  assign thresh_hit = (thresh != '0) && (count >= thresh);
  assign rd_data    = mem[rd_ptr];

  // A pop frees the slot a full-FIFO push writes into (pass-through).
  assign pop_ok    = rd_en && !empty && !flush;
  assign push_ok   = wr_en && !flush && (!full || pop_ok);
  assign ovf_event = wr_en && full && !pop_ok && !flush;
  assign unf_event = rd_en && empty && !flush;

  // Storage array; intentionally not reset.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // Pointers and occupancy; power-of-two depth lets pointers wrap naturally.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Sticky error flags; a new event outranks clr_err, flush leaves them alone.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (ovf_event) begin
        overflow <= 1'b1;
      end else if (clr_err) begin
        overflow <= 1'b0;
      end
      if (unf_event) begin
        underflow <= 1'b1;
      end else if (clr_err) begin
        underflow <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_param_fifo.sv
// tb_uart_param_fifo: table-driven status checks plus hand-written corner
// sequences for uart_param_fifo (DEPTH=16, DATA_W=8); popped data is checked
// against a scoreboard queue filled as pushes are driven.
module tb_uart_param_fifo;

  logic       clk = 1'b0;
  logic       reset;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       rd_en;
  logic [7:0] rd_data;
  logic       flush;
  logic [4:0] thresh;
  logic       clr_err;
  logic [4:0] level;
  logic       full;
  logic       empty;
  logic       thresh_hit;
  logic       overflow;
  logic       underflow;

  int n_cmp = 0;
  int n_err = 0;
  logic [7:0] sb [$];

  typedef struct {
    logic       wr;
    logic [7:0] wd;
    logic       rd;
    logic       fl;
    logic       clr;
    logic [4:0] th;
    logic [4:0] lvl;
    logic       emp;
    logic       ful;
    logic       hit;
    logic       ovf;
    logic       unf;
    logic       crd;
    logic [7:0] rdv;
  } vec_t;

  vec_t tbl [$];

  uart_param_fifo #(.DATA_W(8), .DEPTH(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .wr_en      (wr_en),
    .wr_data    (wr_data),
    .rd_en      (rd_en),
    .rd_data    (rd_data),
    .flush      (flush),
    .thresh     (thresh),
    .clr_err    (clr_err),
    .level      (level),
    .full       (full),
    .empty      (empty),
    .thresh_hit (thresh_hit),
    .overflow   (overflow),
    .underflow  (underflow)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic wr, input logic [7:0] wd, input logic rd,
                              input logic fl, input logic clr, input logic [4:0] th,
                              input logic [4:0] lvl, input logic emp, input logic ful,
                              input logic hit, input logic ovf, input logic unf,
                              input logic crd, input logic [7:0] rdv);
    vec_t v;
    v.wr = wr; v.wd = wd; v.rd = rd; v.fl = fl; v.clr = clr; v.th = th;
    v.lvl = lvl; v.emp = emp; v.ful = ful; v.hit = hit; v.ovf = ovf; v.unf = unf;
    v.crd = crd; v.rdv = rdv;
    return v;
  endfunction

  // One clock: drive, check the head against the scoreboard on a pop, update queue.
  task automatic step(input logic w, input logic [7:0] d, input logic r,
                      input logic f, input logic c);
    bit pop;
    bit push;
    wr_en = w; wr_data = d; rd_en = r; flush = f; clr_err = c;
    pop  = r && (sb.size() > 0) && !f;
    push = w && !f && ((sb.size() < 16) || pop);
    if (pop) chk("rd_data", 32'(rd_data), 32'(sb[0]));
    @(posedge clk);
    #1;
    if (f) begin
      sb.delete();
    end else begin
      if (pop) void'(sb.pop_front());
      if (push) sb.push_back(d);
    end
    wr_en = 1'b0; rd_en = 1'b0; flush = 1'b0; clr_err = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    wr_en = 1'b0; wr_data = '0; rd_en = 1'b0; flush = 1'b0; clr_err = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    sb.delete();
  endtask

  task automatic chk_status(input string tag, input logic [4:0] lvl, input logic emp,
                            input logic ful, input logic ovf, input logic unf);
    chk({tag, ".level"}, 32'(level), 32'(lvl));
    chk({tag, ".empty"}, 32'(empty), 32'(emp));
    chk({tag, ".full"}, 32'(full), 32'(ful));
    chk({tag, ".overflow"}, 32'(overflow), 32'(ovf));
    chk({tag, ".underflow"}, 32'(underflow), 32'(unf));
  endtask

  initial begin
    thresh = 5'd8;
    do_reset();
    chk_status("reset", 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("reset.thresh_hit", 32'(thresh_hit), 32'(0));

    // Table: underflow, push-on-empty with rd, watermark, flush priority.
    tbl.push_back(mk(0, 8'h00, 1, 0, 0, 5'd8,  5'd0, 1, 0, 0, 0, 1, 0, 8'h00));
    tbl.push_back(mk(1, 8'h33, 1, 0, 0, 5'd8,  5'd1, 0, 0, 0, 0, 1, 1, 8'h33));
    tbl.push_back(mk(0, 8'h00, 0, 0, 1, 5'd8,  5'd1, 0, 0, 0, 0, 0, 1, 8'h33));
    for (int i = 2; i <= 7; i++)
      tbl.push_back(mk(1, 8'(8'h32 + i), 0, 0, 0, 5'd8, 5'(i), 0, 0, 0, 0, 0, 1, 8'h33));
    tbl.push_back(mk(1, 8'h3A, 0, 0, 0, 5'd8,  5'd8, 0, 0, 1, 0, 0, 1, 8'h33));
    tbl.push_back(mk(0, 8'h00, 0, 0, 0, 5'd0,  5'd8, 0, 0, 0, 0, 0, 0, 8'h00));
    tbl.push_back(mk(0, 8'h00, 0, 0, 0, 5'd16, 5'd8, 0, 0, 0, 0, 0, 0, 8'h00));
    tbl.push_back(mk(0, 8'h00, 0, 0, 0, 5'd14, 5'd8, 0, 0, 0, 0, 0, 0, 8'h00));
    tbl.push_back(mk(0, 8'h00, 0, 0, 0, 5'd8,  5'd8, 0, 0, 1, 0, 0, 0, 8'h00));
    tbl.push_back(mk(1, 8'hEE, 1, 1, 0, 5'd8,  5'd0, 1, 0, 0, 0, 0, 0, 8'h00));
    tbl.push_back(mk(0, 8'h00, 1, 1, 0, 5'd0,  5'd0, 1, 0, 0, 0, 0, 0, 8'h00));

    foreach (tbl[i]) begin
      thresh = tbl[i].th;
      step(tbl[i].wr, tbl[i].wd, tbl[i].rd, tbl[i].fl, tbl[i].clr);
      chk_status($sformatf("vec%0d", i), tbl[i].lvl, tbl[i].emp, tbl[i].ful,
                 tbl[i].ovf, tbl[i].unf);
      chk($sformatf("vec%0d.thresh_hit", i), 32'(thresh_hit), 32'(tbl[i].hit));
      if (tbl[i].crd) chk($sformatf("vec%0d.rd_data", i), 32'(rd_data), 32'(tbl[i].rdv));
    end

    // Fill 0x00..0x0F then drain in order.
    thresh = 5'd8;
    do_reset();
    for (int i = 0; i < 16; i++) step(1, 8'(i), 0, 0, 0);
    chk_status("fill16", 5'd16, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 16; i++) step(0, 8'h00, 1, 0, 0);
    chk_status("drain16", 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);

    // Overflow on full, cleared by clr_err; dropped word never read.
    for (int i = 0; i < 16; i++) step(1, 8'(8'h10 + i), 0, 0, 0);
    step(1, 8'hAA, 0, 0, 0);
    chk_status("ovf", 5'd16, 1'b0, 1'b1, 1'b1, 1'b0);
    step(0, 8'h00, 0, 0, 1);
    chk_status("ovf_clr", 5'd16, 1'b0, 1'b1, 1'b0, 1'b0);

    // Pass-through push+pop while full; 0x55 comes out last.
    step(1, 8'h55, 1, 0, 0);
    chk_status("passthru", 5'd16, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("passthru.head", 32'(rd_data), 32'(8'h11));
    for (int i = 0; i < 15; i++) step(0, 8'h00, 1, 0, 0);
    chk("passthru.last", 32'(rd_data), 32'(8'h55));
    step(0, 8'h00, 1, 0, 0);
    chk_status("passthru_end", 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);

    // Wrapped pointers, level 10, flush keeps sticky flags.
    do_reset();
    step(0, 8'h00, 1, 0, 0);
    for (int i = 0; i < 14; i++) step(1, 8'(8'h40 + i), 0, 0, 0);
    for (int i = 0; i < 14; i++) step(0, 8'h00, 1, 0, 0);
    for (int i = 0; i < 10; i++) step(1, 8'(8'h60 + i), 0, 0, 0);
    chk_status("wrap10", 5'd10, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1, 8'hBB, 0, 1, 0);
    chk_status("flush", 5'd0, 1'b1, 1'b0, 1'b0, 1'b1);
    step(1, 8'h77, 0, 0, 0);
    chk("flush.rt_head", 32'(rd_data), 32'(8'h77));
    step(0, 8'h00, 1, 0, 0);
    chk_status("flush_rt", 5'd0, 1'b1, 1'b0, 1'b0, 1'b1);

    // Asynchronous reset mid-stream clears level before any edge.
    for (int i = 0; i < 3; i++) step(1, 8'(8'h80 + i), 0, 0, 0);
    reset = 1'b1;
    #1;
    chk_status("async_rst", 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    sb.delete();
    step(1, 8'h99, 0, 0, 0);
    chk("post_rst.head", 32'(rd_data), 32'(8'h99));
    step(0, 8'h00, 1, 0, 0);
    chk_status("post_rst", 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
